// File: rtl/video_stream_gen.sv
// Multi-pixel video test-pattern transmitter: PX_PER_CLK pixels per clock with line/frame
// markers, programmable horizontal/vertical blanking and four selectable patterns.
module video_stream_gen #(
    parameter int unsigned PX_WIDTH      = 12,
    parameter int unsigned PX_PER_CLK    = 4,
    parameter int unsigned MAX_LINE_SIZE = 4112,
    parameter int unsigned MAX_LINES     = 4096
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 en_i,
    input  logic [$clog2(MAX_LINE_SIZE+1)-1:0]   line_size_i,
    input  logic [$clog2(MAX_LINES+1)-1:0]       lines_i,
    input  logic [15:0]                          hblank_i,
    input  logic [15:0]                          vblank_i,
    input  logic [1:0]                           pattern_i,
    input  logic [PX_WIDTH-1:0]                  solid_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0]       px_data_o,
    output logic [PX_PER_CLK-1:0]                px_data_val_o,
    output logic                                 line_start_o,
    output logic                                 line_end_o,
    output logic                                 frame_start_o,
    output logic                                 frame_end_o,
    output logic                                 busy_o
);

    localparam int unsigned LS_W = $clog2(MAX_LINE_SIZE + 1);
    localparam int unsigned LN_W = $clog2(MAX_LINES + 1);
    // Wide enough for x + PX_PER_CLK at the largest line without wrapping.
    localparam int unsigned XW   = $clog2(MAX_LINE_SIZE + PX_PER_CLK + 1);
    localparam int unsigned DW   = PX_PER_CLK * PX_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHblank,
        StVblank
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [LS_W-1:0]     r_x;
    logic [LS_W-1:0]     w_x_d;
    logic [LN_W-1:0]     r_y;
    logic [LN_W-1:0]     w_y_d;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_d;

    logic [LS_W-1:0]     r_line_size;
    logic [LN_W-1:0]     r_lines;
    logic [15:0]         r_hblank;
    logic [15:0]         r_vblank;
    logic [1:0]          r_pattern;
    logic [PX_WIDTH-1:0] r_solid;

    logic                w_start_ok;
    logic                w_load;
    logic                w_emit;
    logic                w_restart;
    logic                w_last_word;
    logic                w_last_line;

    logic [LS_W-1:0]     w_ls;
    logic [LN_W-1:0]     w_lines;
    logic [1:0]          w_pat;
    logic [PX_WIDTH-1:0] w_solid;

    logic [XW-1:0]       w_px;
    logic [PX_WIDTH-1:0] w_pix;
    logic [DW-1:0]       w_px_data;
    logic [PX_PER_CLK-1:0] w_px_val;
    logic                w_line_start;
    logic                w_line_end;
    logic                w_frame_start;
    logic                w_frame_end;

    logic [DW-1:0]       r_px_data;
    logic [PX_PER_CLK-1:0] r_px_val;
    logic                r_line_start;
    logic                r_line_end;
    logic                r_frame_start;
    logic                r_frame_end;
    logic                r_busy;

    assign w_start_ok  = en_i && (line_size_i != '0) && (lines_i != '0);
    assign w_last_word = (XW'(r_x) + XW'(PX_PER_CLK)) >= XW'(r_line_size);
    assign w_last_line = (r_y == r_lines - LN_W'(1));

    // Next-state logic; counters describe the word that will be shown after the edge.
    always_comb begin
        w_state_d = r_state;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_cnt_d   = r_cnt;
        w_load    = 1'b0;
        w_emit    = 1'b0;
        w_restart = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_restart = 1'b1;
            end
            StActive: begin
                if (!w_last_word) begin
                    w_x_d  = r_x + LS_W'(PX_PER_CLK);
                    w_emit = 1'b1;
                end else if (!w_last_line) begin
                    w_x_d = '0;
                    if (r_hblank == '0) begin
                        w_y_d  = r_y + LN_W'(1);
                        w_emit = 1'b1;
                    end else begin
                        w_state_d = StHblank;
                        w_cnt_d   = r_hblank - 16'd1;
                    end
                end else if (r_vblank == '0) begin
                    w_restart = 1'b1;
                end else begin
                    w_state_d = StVblank;
                    w_x_d     = '0;
                    w_cnt_d   = r_vblank - 16'd1;
                end
            end
            StHblank: begin
                if (r_cnt == '0) begin
                    w_state_d = StActive;
                    w_y_d     = r_y + LN_W'(1);
                    w_emit    = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 16'd1;
                end
            end
            StVblank: begin
                if (r_cnt == '0) begin
                    w_restart = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Frame boundary: either start a fresh frame with newly latched config or park.
        if (w_restart) begin
            w_x_d   = '0;
            w_y_d   = '0;
            w_cnt_d = '0;
            if (w_start_ok) begin
                w_state_d = StActive;
                w_load    = 1'b1;
                w_emit    = 1'b1;
            end else begin
                w_state_d = StIdle;
            end
        end
    end

    // The first word of a frame must already use the configuration being latched.
    assign w_ls    = w_load ? line_size_i : r_line_size;
    assign w_lines = w_load ? lines_i     : r_lines;
    assign w_pat   = w_load ? pattern_i   : r_pattern;
    assign w_solid = w_load ? solid_i     : r_solid;

    always_comb begin
        w_px      = '0;
        w_pix     = '0;
        w_px_data = '0;
        w_px_val  = '0;
        for (int i = 0; i < int'(PX_PER_CLK); i++) begin
            w_px = XW'(w_x_d) + XW'(i);
            unique case (w_pat)
                2'd0:    w_pix = PX_WIDTH'(w_px);
                2'd1:    w_pix = PX_WIDTH'(w_y_d);
                2'd2:    w_pix = w_solid;
                default: w_pix = (w_px[3] ^ w_y_d[3]) ? '1 : '0;
            endcase
            if (w_emit && (w_px < XW'(w_ls))) begin
                w_px_val[i]                       = 1'b1;
                w_px_data[i*PX_WIDTH +: PX_WIDTH] = w_pix;
            end
        end
    end

    assign w_line_start  = w_emit && (w_x_d == '0);
    assign w_line_end    = w_emit && ((XW'(w_x_d) + XW'(PX_PER_CLK)) >= XW'(w_ls));
    assign w_frame_start = w_line_start && (w_y_d == '0);
    assign w_frame_end   = w_line_end && (w_y_d == w_lines - LN_W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StIdle;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_line_size <= '0;
            r_lines     <= '0;
            r_hblank    <= '0;
            r_vblank    <= '0;
            r_pattern   <= '0;
            r_solid     <= '0;
        end else begin
            r_state <= w_state_d;
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_cnt   <= w_cnt_d;
            if (w_load) begin
                r_line_size <= line_size_i;
                r_lines     <= lines_i;
                r_hblank    <= hblank_i;
                r_vblank    <= vblank_i;
                r_pattern   <= pattern_i;
                r_solid     <= solid_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_px_data     <= '0;
            r_px_val      <= '0;
            r_line_start  <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_px_data     <= w_px_data;
            r_px_val      <= w_px_val;
            r_line_start  <= w_line_start;
            r_line_end    <= w_line_end;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_busy        <= (w_state_d != StIdle);
        end
    end

    assign px_data_o     = r_px_data;
    assign px_data_val_o = r_px_val;
    assign line_start_o  = r_line_start;
    assign line_end_o    = r_line_end;
    assign frame_start_o = r_frame_start;
    assign frame_end_o   = r_frame_end;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen: hand-computed words, markers and blanking per cycle.
module tb_video_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en;
    logic [12:0] line_size;
    logic [12:0] lines;
    logic [15:0] hblank;
    logic [15:0] vblank;
    logic [1:0]  pattern;
    logic [11:0] solid;
    logic [47:0] px_data;
    logic [3:0]  px_val;
    logic        line_start;
    logic        line_end;
    logic        frame_start;
    logic        frame_end;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [47:0] W0 = 48'h003_002_001_000;
    localparam logic [47:0] W1 = 48'h007_006_005_004;

    video_stream_gen dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .line_size_i   (line_size),
        .lines_i       (lines),
        .hblank_i      (hblank),
        .vblank_i      (vblank),
        .pattern_i     (pattern),
        .solid_i       (solid),
        .px_data_o     (px_data),
        .px_data_val_o (px_val),
        .line_start_o  (line_start),
        .line_end_o    (line_end),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Observed bundle: {busy, frame_start, frame_end, line_start, line_end, val, data}.
    logic [56:0] obs;
    assign obs = {busy, frame_start, frame_end, line_start, line_end, px_val, px_data};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_check(input string tag, input logic b, input logic [3:0] mk,
                              input logic [3:0] val, input logic [47:0] data);
        @(negedge clk);
        check_eq(tag, {7'd0, obs}, {7'd0, b, mk, val, data});
    endtask

    task automatic set_cfg(input logic [12:0] ls, input logic [12:0] ln, input logic [15:0] hb,
                           input logic [15:0] vb, input logic [1:0] pat, input logic [11:0] sol);
        line_size = ls;
        lines     = ln;
        hblank    = hb;
        vblank    = vb;
        pattern   = pat;
        solid     = sol;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        en = 1'b0;
        set_cfg(13'd8, 13'd2, 16'd2, 16'd3, 2'd0, 12'h000);
        #1 rst_n = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {7'd0, obs}, 64'd0);
        en = 1'b0;
        rst_n = 1'b1;
        step_check("idle_after_reset", 1'b0, 4'b0000, 4'h0, 48'h0);

        // Two-line frame with blanking, then a second frame that ends with en low.
        en = 1'b1;
        step_check("A_l0w0", 1'b1, 4'b1010, 4'hF, W0);
        step_check("A_l0w1", 1'b1, 4'b0001, 4'hF, W1);
        repeat (2) step_check("A_hblank", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("A_l1w0", 1'b1, 4'b0010, 4'hF, W0);
        step_check("A_l1w1", 1'b1, 4'b0101, 4'hF, W1);
        repeat (3) step_check("A_vblank", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("A_f1_l0w0", 1'b1, 4'b1010, 4'hF, W0);
        en = 1'b0;
        step_check("A_f1_l0w1", 1'b1, 4'b0001, 4'hF, W1);
        repeat (2) step_check("A_f1_hblank", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("A_f1_l1w0", 1'b1, 4'b0010, 4'hF, W0);
        step_check("A_f1_l1w1", 1'b1, 4'b0101, 4'hF, W1);
        repeat (3) step_check("A_f1_vblank", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("A_idle", 1'b0, 4'b0000, 4'h0, 48'h0);

        // Partial last word.
        set_cfg(13'd10, 13'd1, 16'd0, 16'd0, 2'd0, 12'h000);
        en = 1'b1;
        step_check("B_w0", 1'b1, 4'b1010, 4'hF, W0);
        en = 1'b0;
        step_check("B_w1", 1'b1, 4'b0000, 4'hF, W1);
        step_check("B_w2_partial", 1'b1, 4'b0101, 4'b0011, 48'h000_000_009_008);
        step_check("B_idle", 1'b0, 4'b0000, 4'h0, 48'h0);

        // One-word single-line frames back to back, solid pattern.
        set_cfg(13'd3, 13'd1, 16'd0, 16'd0, 2'd2, 12'hABC);
        en = 1'b1;
        repeat (3) step_check("C_solid", 1'b1, 4'b1111, 4'b0111, 48'h000_ABC_ABC_ABC);
        en = 1'b0;
        step_check("C_idle", 1'b0, 4'b0000, 4'h0, 48'h0);

        // en dropped in line 0 of a 4-line frame, pattern y.
        set_cfg(13'd4, 13'd4, 16'd1, 16'd2, 2'd1, 12'h000);
        en = 1'b1;
        step_check("D_l0", 1'b1, 4'b1011, 4'hF, 48'h0);
        en = 1'b0;
        step_check("D_hb0", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("D_l1", 1'b1, 4'b0011, 4'hF, 48'h001_001_001_001);
        step_check("D_hb1", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("D_l2", 1'b1, 4'b0011, 4'hF, 48'h002_002_002_002);
        step_check("D_hb2", 1'b1, 4'b0000, 4'h0, 48'h0);
        step_check("D_l3", 1'b1, 4'b0111, 4'hF, 48'h003_003_003_003);
        repeat (2) step_check("D_vblank", 1'b1, 4'b0000, 4'h0, 48'h0);
        repeat (2) step_check("D_idle", 1'b0, 4'b0000, 4'h0, 48'h0);

        // line_size change mid-frame takes effect at the next frame.
        set_cfg(13'd4, 13'd2, 16'd0, 16'd0, 2'd0, 12'h000);
        en = 1'b1;
        step_check("E_f0_l0", 1'b1, 4'b1011, 4'hF, W0);
        line_size = 13'd8;
        step_check("E_f0_l1", 1'b1, 4'b0111, 4'hF, W0);
        step_check("E_f1_l0w0", 1'b1, 4'b1010, 4'hF, W0);
        en = 1'b0;
        step_check("E_f1_l0w1", 1'b1, 4'b0001, 4'hF, W1);
        step_check("E_f1_l1w0", 1'b1, 4'b0010, 4'hF, W0);
        step_check("E_f1_l1w1", 1'b1, 4'b0101, 4'hF, W1);
        step_check("E_idle", 1'b0, 4'b0000, 4'h0, 48'h0);

        // Checkerboard, then asynchronous reset mid-line and a fresh frame.
        set_cfg(13'd16, 13'd2, 16'd0, 16'd0, 2'd3, 12'h000);
        en = 1'b1;
        step_check("F_chk_w0", 1'b1, 4'b1010, 4'hF, 48'h0);
        step_check("F_chk_w1", 1'b1, 4'b0000, 4'hF, 48'h0);
        step_check("F_chk_w2", 1'b1, 4'b0000, 4'hF, 48'hFFF_FFF_FFF_FFF);
        pattern = 2'd0;
        #2 rst_n = 1'b0;
        #1 check_eq("F_async_reset", {7'd0, obs}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_check("F_fresh_w0", 1'b1, 4'b1010, 4'hF, W0);
        en = 1'b0;
        step_check("F_fresh_w1", 1'b1, 4'b0000, 4'hF, W1);
        begin
            int k;
            k = 0;
            while (busy && k < 40) begin
                @(negedge clk);
                k++;
            end
            check_eq("F_drain_busy", {63'd0, busy}, 64'd0);
            check_eq("F_drain_cycles", 64'(k), 64'd7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
